// File: rtl/config_pkg.sv
// ---------------------------------------------------------------------------
// config_pkg
// Shared front-end configuration: address width, fetch alignment, the
// control-flow classification of a fetched slot and the layout of one
// fetch-queue entry.
// ---------------------------------------------------------------------------
package config_pkg;

  // Virtual address width used throughout the front end.
  localparam int VLEN = 32;

  // Instructions are 4-byte aligned: slot i sits at base + (i << FETCH_ALIGN_BITS).
  localparam int FETCH_ALIGN_BITS = 2;

  // Control-flow classification attached to each fetched slot.
  typedef enum logic [2:0] {
    CF_NONE   = 3'd0,
    CF_BRANCH = 3'd1,
    CF_JAL    = 3'd2,
    CF_JALR   = 3'd3,
    CF_RETURN = 3'd4
  } cf_t;

  // One queued instruction together with its predicted successor.
  typedef struct packed {
    logic [VLEN-1:0] address;
    logic [31:0]     instruction;
    cf_t             cf_type;
    logic [VLEN-1:0] predict_address;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_compact.sv
// ---------------------------------------------------------------------------
// fetch_queue_compact
// Slot compaction for the fetch queue: trims the slot mask at the predicted
// taken slot, picks the lowest-indexed effective slots that fit in the free
// space, and locates the first effective slot that did not fit.
//
// Ports
//   slot_valid   in   per-slot valid mask from the fetch block
//   taken_valid  in   a slot is predicted taken
//   taken_slot   in   index of the predicted-taken slot
//   free         in   free queue entries this cycle
//   eff_mask     out  slot_valid with slots after the taken slot cleared
//   acc_mask     out  effective slots that fit into the queue
//   replay_valid out  some effective slot was not accepted
//   replay_slot  out  lowest effective slot that was not accepted
// ---------------------------------------------------------------------------
module fetch_queue_compact #(
  parameter int FETCH_WIDTH = 2,
  parameter int CNT_W       = 4,
  parameter int TS_W        = 1
) (
  input  logic [FETCH_WIDTH-1:0] slot_valid,
  input  logic                   taken_valid,
  input  logic [TS_W-1:0]        taken_slot,
  input  logic [CNT_W-1:0]       free,
  output logic [FETCH_WIDTH-1:0] eff_mask,
  output logic [FETCH_WIDTH-1:0] acc_mask,
  output logic                   replay_valid,
  output logic [TS_W-1:0]        replay_slot
);

  logic [CNT_W-1:0] seen;
  logic             found;

  always_comb begin
    eff_mask = slot_valid;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (taken_valid && (i > int'(taken_slot))) begin
        eff_mask[i] = 1'b0;
      end
    end
  end

  // A slot is accepted when the number of effective slots below it is still
  // under the free-entry budget, so acceptance is always a low-order prefix
  // of the effective slots.
  always_comb begin
    acc_mask = '0;
    seen     = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (eff_mask[i]) begin
        if (seen < free) begin
          acc_mask[i] = 1'b1;
        end
        seen = seen + CNT_W'(1);
      end
    end
  end

  always_comb begin
    replay_slot = '0;
    found       = 1'b0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (eff_mask[i] && !acc_mask[i] && !found) begin
        replay_slot = TS_W'(i);
        found       = 1'b1;
      end
    end
  end

  assign replay_valid = (acc_mask != eff_mask);

endmodule

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Instruction fetch queue between the fetch stage and the decoder. Each cycle
// a fetch block of up to FETCH_WIDTH slots is offered; the lowest effective
// slots that fit are written in order, one entry per slot, and the remainder
// is reported for refetch. The backend pops one entry per cycle from the head.
//
// Optional feature: define FETCH_QUEUE_BYPASS_EN to let the lowest effective
// slot of a block go straight to the head output when the queue is empty and
// the backend is ready. Without it there is no combinational path from
// valid_i to fetch_entry_valid_o.
//
// Ports
//   clk_i               in   clock
//   rst_ni              in   asynchronous active-low reset
//   flush_i             in   discard all queue contents
//   valid_i             in   fetch block present
//   instr_i             in   instruction words, slot 0 in LSBs
//   addr_i              in   address of slot 0
//   slot_valid_i        in   per-slot valid mask
//   cf_type_i           in   per-slot control-flow type
//   taken_valid_i       in   a slot is predicted taken
//   taken_slot_i        in   predicted-taken slot index
//   predict_address_i   in   predicted target of the taken slot
//   backend_ready_i     in   backend accepts the head entry
//   ready_o             out  at least FETCH_WIDTH free entries
//   consumed_o          out  slots accepted this cycle
//   replay_o            out  some effective slot was not accepted
//   replay_addr_o       out  address to refetch from
//   fetch_entry_o       out  head entry
//   fetch_entry_valid_o out  head entry valid
//   count_o             out  occupied entries
// ---------------------------------------------------------------------------
module fetch_queue
  import config_pkg::*;
#(
  parameter int  FETCH_WIDTH = 2,
  parameter int  DEPTH       = 8,
  parameter int  VLEN        = config_pkg::VLEN,
  localparam int TS_W        = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1,
  localparam int CNT_W       = $clog2(DEPTH) + 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic                      valid_i,
  input  logic [32*FETCH_WIDTH-1:0] instr_i,
  input  logic [VLEN-1:0]           addr_i,
  input  logic [FETCH_WIDTH-1:0]    slot_valid_i,
  input  cf_t                       cf_type_i [FETCH_WIDTH],
  input  logic                      taken_valid_i,
  input  logic [TS_W-1:0]           taken_slot_i,
  input  logic [VLEN-1:0]           predict_address_i,
  input  logic                      backend_ready_i,
  output logic                      ready_o,
  output logic [FETCH_WIDTH-1:0]    consumed_o,
  output logic                      replay_o,
  output logic [VLEN-1:0]           replay_addr_o,
  output fetch_entry_t              fetch_entry_o,
  output logic                      fetch_entry_valid_o,
  output logic [CNT_W-1:0]          count_o
);

  localparam int              PTR_W  = $clog2(DEPTH);
  localparam logic [VLEN-1:0] STRIDE = VLEN'(1 << FETCH_ALIGN_BITS);

  logic [PTR_W-1:0]       wr_ptr_q;
  logic [PTR_W-1:0]       rd_ptr_q;
  logic [CNT_W-1:0]       count_q;
  fetch_entry_t           mem_q [DEPTH];

  fetch_entry_t           slot_entry [FETCH_WIDTH];
  fetch_entry_t           head_entry;
  logic [FETCH_WIDTH-1:0] eff_mask;
  logic [FETCH_WIDTH-1:0] acc_mask;
  logic [FETCH_WIDTH-1:0] wr_mask;
  logic                   replay_valid;
  logic [TS_W-1:0]        replay_slot;
  logic [CNT_W-1:0]       free;
  logic [CNT_W-1:0]       n_write;
  logic [PTR_W-1:0]       wr_pos [FETCH_WIDTH];
  logic                   push_ok;
  logic                   pop;

  // Entries popped this cycle do not count as free space.
  assign free    = CNT_W'(DEPTH) - count_q;
  assign push_ok = valid_i & ~flush_i;
  assign pop     = (count_q != '0) & ~flush_i & backend_ready_i;

  // Per-slot entry contents; the taken slot carries the predicted target,
  // every other slot falls through to the next sequential instruction.
  always_comb begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      slot_entry[i].address     = addr_i + STRIDE * VLEN'(i);
      slot_entry[i].instruction = instr_i[32*i +: 32];
      slot_entry[i].cf_type     = cf_type_i[i];
      if (taken_valid_i && (int'(taken_slot_i) == i)) begin
        slot_entry[i].predict_address = predict_address_i;
      end else begin
        slot_entry[i].predict_address = slot_entry[i].address + STRIDE;
      end
    end
  end

  fetch_queue_compact #(
    .FETCH_WIDTH (FETCH_WIDTH),
    .CNT_W       (CNT_W),
    .TS_W        (TS_W)
  ) u_compact (
    .slot_valid   (slot_valid_i),
    .taken_valid  (taken_valid_i),
    .taken_slot   (taken_slot_i),
    .free         (free),
    .eff_mask     (eff_mask),
    .acc_mask     (acc_mask),
    .replay_valid (replay_valid),
    .replay_slot  (replay_slot)
  );

  assign consumed_o    = push_ok ? acc_mask : '0;
  assign replay_o      = push_ok & replay_valid;
  assign replay_addr_o = replay_o ? (addr_i + STRIDE * VLEN'(replay_slot)) : '0;
  assign ready_o       = (free >= CNT_W'(FETCH_WIDTH));
  assign count_o       = count_q;

  // The head reads as all-zero while the queue is empty so the output is
  // clean out of reset even though the storage itself is not reset.
  assign head_entry = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic                   bypass;
  logic [TS_W-1:0]        byp_slot;
  logic [FETCH_WIDTH-1:0] byp_onehot;

  // Lowest effective slot: scanning downward leaves the smallest index.
  always_comb begin
    byp_slot   = '0;
    byp_onehot = '0;
    for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
      if (eff_mask[i]) begin
        byp_slot      = TS_W'(i);
        byp_onehot    = '0;
        byp_onehot[i] = 1'b1;
      end
    end
  end

  // On an empty queue every effective slot fits, so the bypassed slot is
  // always among the accepted ones and is simply not written.
  assign bypass              = (count_q == '0) & push_ok & backend_ready_i & (|eff_mask);
  assign wr_mask             = push_ok ? (acc_mask & ~({FETCH_WIDTH{bypass}} & byp_onehot)) : '0;
  assign fetch_entry_o       = bypass ? slot_entry[byp_slot] : head_entry;
  assign fetch_entry_valid_o = ((count_q != '0) & ~flush_i) | bypass;
`else
  assign wr_mask             = push_ok ? acc_mask : '0;
  assign fetch_entry_o       = head_entry;
  assign fetch_entry_valid_o = (count_q != '0) & ~flush_i;
`endif

  // Written slots land in consecutive entries starting at the write pointer,
  // in ascending slot order.
  always_comb begin
    n_write = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      wr_pos[i] = wr_ptr_q + n_write[PTR_W-1:0];
      if (wr_mask[i]) begin
        n_write = n_write + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + n_write[PTR_W-1:0];
      rd_ptr_q <= rd_ptr_q + PTR_W'(pop);
      count_q  <= count_q + n_write - CNT_W'(pop);
    end
  end

  // Entry storage carries data only and is left unreset.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (wr_mask[i]) begin
        mem_q[wr_pos[i]] <= slot_entry[i];
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
// Self-checking bench for fetch_queue with FETCH_WIDTH=2, DEPTH=4.
// A directed vector table, a few hand sequences and randomized traffic are
// compared against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_fetch_queue;
  import config_pkg::*;

  localparam int FW = 2;
  localparam int D  = 4;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          valid;
  logic [63:0]   instr;
  logic [31:0]   addr;
  logic [1:0]    slot_valid;
  cf_t           cf_type [FW];
  logic          taken_valid;
  logic [0:0]    taken_slot;
  logic [31:0]   predict;
  logic          bready;
  logic          ready;
  logic [1:0]    consumed;
  logic          replay;
  logic [31:0]   replay_addr;
  fetch_entry_t  entry;
  logic          entry_valid;
  logic [2:0]    count;

  fetch_queue #(.FETCH_WIDTH(FW), .DEPTH(D)) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .flush_i             (flush),
    .valid_i             (valid),
    .instr_i             (instr),
    .addr_i              (addr),
    .slot_valid_i        (slot_valid),
    .cf_type_i           (cf_type),
    .taken_valid_i       (taken_valid),
    .taken_slot_i        (taken_slot),
    .predict_address_i   (predict),
    .backend_ready_i     (bready),
    .ready_o             (ready),
    .consumed_o          (consumed),
    .replay_o            (replay),
    .replay_addr_o       (replay_addr),
    .fetch_entry_o       (entry),
    .fetch_entry_valid_o (entry_valid),
    .count_o             (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  fetch_entry_t mq [$];
  fetch_entry_t m_slot [FW];
  logic [1:0]   m_wr;
  logic         m_fl;
  logic         m_pop;

  task automatic check_model();
    logic [1:0]   eff;
    int           free;
    int           idx [$];
    int           n_acc;
    logic         live;
    logic         byp;
    logic [1:0]   acc;
    logic         e_rep;
    logic [31:0]  e_raddr;
    logic         e_hv;
    fetch_entry_t e_ent;
    for (int i = 0; i < FW; i++) begin
      m_slot[i].address     = addr + 32'(4 * i);
      m_slot[i].instruction = instr[32*i +: 32];
      m_slot[i].cf_type     = cf_type[i];
      m_slot[i].predict_address = (taken_valid && int'(taken_slot) == i) ? predict
                                                                         : m_slot[i].address + 32'd4;
    end
    eff = slot_valid;
    for (int i = 0; i < FW; i++)
      if (taken_valid && i > int'(taken_slot)) eff[i] = 1'b0;
    for (int i = 0; i < FW; i++)
      if (eff[i]) idx.push_back(i);
    free  = D - mq.size();
    n_acc = (idx.size() < free) ? idx.size() : free;
    acc   = '0;
    for (int k = 0; k < n_acc; k++) acc[idx[k]] = 1'b1;
    live = valid && !flush;
    byp  = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = live && bready && (mq.size() == 0) && (idx.size() > 0);
`endif
    m_wr = live ? acc : 2'b00;
    if (byp) m_wr[idx[0]] = 1'b0;
    m_fl  = flush;
    m_pop = (mq.size() != 0) && !flush && bready;
    e_rep   = live && (n_acc < idx.size());
    e_raddr = e_rep ? addr + 32'(4 * idx[n_acc]) : 32'd0;
    e_hv    = byp || ((mq.size() != 0) && !flush);
    if (byp)                e_ent = m_slot[idx[0]];
    else if (mq.size() != 0) e_ent = mq[0];
    else                    e_ent = '0;
    chk("m_count", count, mq.size());
    chk("m_ready", ready, free >= FW);
    chk("m_consumed", consumed, live ? acc : 2'b00);
    chk("m_replay", replay, e_rep);
    chk("m_replay_addr", replay_addr, e_raddr);
    chk("m_head_valid", entry_valid, e_hv);
    if (e_hv || mq.size() == 0) chk("m_head_entry", entry, e_ent);
  endtask

  task automatic tick();
    @(posedge clk);
    if (m_fl) mq.delete();
    else begin
      if (m_pop) void'(mq.pop_front());
      for (int i = 0; i < FW; i++)
        if (m_wr[i]) mq.push_back(m_slot[i]);
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic fl, input logic v, input logic [31:0] a, input logic [1:0] m,
                       input logic tv, input logic ts, input logic [31:0] tgt, input logic br);
    flush       = fl;
    valid       = v;
    addr        = a;
    slot_valid  = m;
    taken_valid = tv;
    taken_slot  = ts;
    predict     = tgt;
    bready      = br;
    instr       = {$urandom, $urandom};
    for (int i = 0; i < FW; i++) cf_type[i] = cf_t'($urandom_range(0, 4));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        fl, v;
    logic [31:0] a;
    logic [1:0]  m;
    logic        tv, ts;
    logic [31:0] tgt;
    logic        br;
    logic [2:0]  e_cnt;
    logic        e_rdy;
    logic [1:0]  e_cons;
    logic        e_rep;
    logic [31:0] e_raddr;
    logic        e_hv;
    logic [31:0] e_haddr, e_hpred;
  } vec_t;

  function automatic vec_t mk(logic fl, logic v, logic [31:0] a, logic [1:0] m, logic tv, logic ts,
                              logic [31:0] tgt, logic br, logic [2:0] cnt, logic rdy, logic [1:0] cons,
                              logic rep, logic [31:0] raddr, logic hv, logic [31:0] haddr,
                              logic [31:0] hpred);
    vec_t r;
    r.fl = fl; r.v = v; r.a = a; r.m = m; r.tv = tv; r.ts = ts; r.tgt = tgt; r.br = br;
    r.e_cnt = cnt; r.e_rdy = rdy; r.e_cons = cons; r.e_rep = rep; r.e_raddr = raddr;
    r.e_hv = hv; r.e_haddr = haddr; r.e_hpred = hpred;
    return r;
  endfunction

  vec_t tbl [17];
  int   seen;

  initial begin
    tbl[0]  = mk(0,1,32'h8000_0000,2'b11,0,0,0,0,            0,1,2'b11,0,0,           0,0,0);
    tbl[1]  = mk(0,1,32'h8000_0008,2'b01,0,0,0,0,            2,1,2'b01,0,0,           1,32'h8000_0000,32'h8000_0004);
    tbl[2]  = mk(0,1,32'h8000_0010,2'b11,0,0,0,0,            3,0,2'b01,1,32'h8000_0014,1,32'h8000_0000,32'h8000_0004);
    tbl[3]  = mk(0,1,32'h8000_0020,2'b11,0,0,0,1,            4,0,2'b00,1,32'h8000_0020,1,32'h8000_0000,32'h8000_0004);
    tbl[4]  = mk(0,0,0,2'b00,0,0,0,0,                        3,0,2'b00,0,0,           1,32'h8000_0004,32'h8000_0008);
    tbl[5]  = mk(1,1,32'h8000_0030,2'b11,0,0,0,1,            3,0,2'b00,0,0,           0,0,0);
    tbl[6]  = mk(0,0,0,2'b00,0,0,0,0,                        0,1,2'b00,0,0,           0,0,0);
    tbl[7]  = mk(0,1,32'h8000_0040,2'b11,1,0,32'h8000_0100,0,0,1,2'b01,0,0,           0,0,0);
    tbl[8]  = mk(0,1,32'h8000_0050,2'b11,1,1,32'h8000_0200,1,1,1,2'b11,0,0,           1,32'h8000_0040,32'h8000_0100);
    tbl[9]  = mk(0,1,32'h8000_0060,2'b00,0,0,0,1,            2,1,2'b00,0,0,           1,32'h8000_0050,32'h8000_0054);
    tbl[10] = mk(0,1,32'h8000_0070,2'b10,0,0,0,1,            1,1,2'b10,0,0,           1,32'h8000_0054,32'h8000_0200);
    tbl[11] = mk(0,1,32'h8000_0080,2'b10,1,0,0,0,            1,1,2'b00,0,0,           1,32'h8000_0074,32'h8000_0078);
    tbl[12] = mk(1,0,0,2'b00,0,0,0,0,                        1,1,2'b00,0,0,           0,0,0);
    tbl[13] = mk(0,1,32'hFFFF_FFFC,2'b11,0,0,0,0,            0,1,2'b11,0,0,           0,0,0);
    tbl[14] = mk(0,0,0,2'b00,0,0,0,1,                        2,1,2'b00,0,0,           1,32'hFFFF_FFFC,32'h0000_0000);
    tbl[15] = mk(0,0,0,2'b00,0,0,0,1,                        1,1,2'b00,0,0,           1,32'h0000_0000,32'h0000_0004);
    tbl[16] = mk(0,0,0,2'b00,0,0,0,0,                        0,1,2'b00,0,0,           0,0,0);

    // Reset state
    rst_n = 1'b0;
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count, 3'd0);
    chk("rst_head_valid", entry_valid, 1'b0);
    chk("rst_replay", replay, 1'b0);
    chk("rst_consumed", consumed, 2'b00);
    chk("rst_entry", entry, 128'd0);
    chk("rst_ready", ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table
    for (int k = 0; k < 17; k++) begin
      drive(tbl[k].fl, tbl[k].v, tbl[k].a, tbl[k].m, tbl[k].tv, tbl[k].ts, tbl[k].tgt, tbl[k].br);
      #1;
      chk($sformatf("v%0d_count", k), count, tbl[k].e_cnt);
      chk($sformatf("v%0d_ready", k), ready, tbl[k].e_rdy);
      chk($sformatf("v%0d_consumed", k), consumed, tbl[k].e_cons);
      chk($sformatf("v%0d_replay", k), replay, tbl[k].e_rep);
      chk($sformatf("v%0d_replay_addr", k), replay_addr, tbl[k].e_raddr);
      chk($sformatf("v%0d_head_valid", k), entry_valid, tbl[k].e_hv);
      if (tbl[k].e_hv || tbl[k].e_cnt == 0) begin
        chk($sformatf("v%0d_head_addr", k), entry.address, tbl[k].e_haddr);
        chk($sformatf("v%0d_head_pred", k), entry.predict_address, tbl[k].e_hpred);
      end
      check_model();
      tick();
    end

    // Single-slot stream across pointer wrap, one pop per cycle
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      drive(0, 1, 32'h1000 + 32'(4 * k), 2'b01, 0, 0, 0, 1);
      #1;
      check_model();
      if (entry_valid) begin
        chk($sformatf("stream_%0d", seen), entry.address, 32'h1000 + 32'(4 * seen));
        seen++;
      end
      tick();
    end
    for (int k = 0; k < 6 && seen < 12; k++) begin
      drive(0, 0, 0, 2'b00, 0, 0, 0, 1);
      #1;
      check_model();
      if (entry_valid) begin
        chk($sformatf("stream_%0d", seen), entry.address, 32'h1000 + 32'(4 * seen));
        seen++;
      end
      tick();
    end
    chk("stream_total", seen, 12);

    // Push onto an empty queue with the backend ready
    drive(0, 1, 32'h2000, 2'b01, 0, 0, 0, 1);
    #1;
    check_model();
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("byp_same_valid", entry_valid, 1'b1);
    chk("byp_same_addr", entry.address, 32'h2000);
    tick();
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
    #1;
    chk("byp_next_count", count, 3'd0);
    check_model();
`else
    chk("nobyp_same_valid", entry_valid, 1'b0);
    tick();
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
    #1;
    chk("nobyp_next_valid", entry_valid, 1'b1);
    chk("nobyp_next_addr", entry.address, 32'h2000);
    chk("nobyp_next_count", count, 3'd1);
    check_model();
`endif
    tick();

    // Reset in the middle of a cycle
    drive(0, 1, 32'h3000, 2'b11, 0, 0, 0, 0);
    #1;
    check_model();
    tick();
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", count, 3'd0);
    chk("async_rst_head_valid", entry_valid, 1'b0);
    chk("async_rst_entry", entry, 128'd0);
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      drive(($urandom % 16) == 0, ($urandom % 4) != 0, $urandom & 32'hFFFF_FFFC,
            2'($urandom), 1'($urandom), 1'($urandom), $urandom & 32'hFFFF_FFFC,
            ($urandom % 3) != 0);
      #1;
      check_model();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
